// File: rtl/i8254_count_reader.sv
// Read side of one 8254 counter channel: control-word decode, counter-latch command and byte-wise
// count readback. Optional read-back status support is enabled by defining READBACK_STATUS_EN.
module i8254_count_reader #(
    parameter int unsigned COUNT_W  = 16,
    parameter logic [1:0]  RESET_RW = 2'b11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cw_valid,
    input  logic [1:0]         cw_rw,
    input  logic [2:0]         cw_mode,
    input  logic               cw_bcd,
    input  logic               rd_req,
    input  logic [COUNT_W-1:0] count_value,
    input  logic               out_pin,
    input  logic               count_loaded,
`ifdef READBACK_STATUS_EN
    input  logic               rb_status,
`endif
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               latched
);

    if (COUNT_W != 16) begin : g_count_w_check
        $error("i8254_count_reader: COUNT_W must be 16");
    end

    typedef enum logic {
        ST_FREE    = 1'b0,
        ST_LATCHED = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   rw_q, rw_d;
    logic [2:0]   mode_q, mode_d;
    logic         bcd_q, bcd_d;
    logic [15:0]  latch_q, latch_d;
    logic         byte_ptr_q, byte_ptr_d;
    logic         null_count_q, null_count_d;
    logic [7:0]   rd_data_q, rd_data_d;
    logic         rd_valid_q, rd_valid_d;

    logic         status_sel_s;
    logic         count_rd_s;
    logic         read_done_s;
    logic [15:0]  src_s;
    logic [7:0]   count_byte_s;
    logic         latch_cmd_s;
    logic         rw_write_s;
    state_t       post_read_state_s;

    assign latch_cmd_s = cw_valid && (cw_rw == 2'b00);
    assign rw_write_s  = cw_valid && (cw_rw != 2'b00);

`ifdef READBACK_STATUS_EN
    logic [7:0] status_q, status_d;
    logic       status_pending_q, status_pending_d;

    assign status_sel_s = status_pending_q;

    // Status snapshot uses the pre-update register values; a pending snapshot blocks new ones.
    always_comb begin
        status_q_d_default: begin
            status_d         = status_q;
            status_pending_d = status_pending_q;
        end
        if (rd_req && status_pending_q) begin
            status_pending_d = 1'b0;
        end else begin
            status_pending_d = status_pending_q;
        end
        if (rb_status && !status_pending_q) begin
            status_d         = {out_pin, null_count_q, rw_q, mode_q, bcd_q};
            status_pending_d = 1'b1;
        end else begin
            status_d         = status_q;
        end
    end

    // Status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q         <= 8'h00;
            status_pending_q <= 1'b0;
        end else begin
            status_q         <= status_d;
            status_pending_q <= status_pending_d;
        end
    end
`else
    logic unused_s;

    assign status_sel_s = 1'b0;
    assign unused_s     = ^{mode_q, bcd_q, null_count_q, out_pin};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a read that completes the latched value frees it before the control word applies
    always_comb begin
        if (read_done_s) begin
            post_read_state_s = ST_FREE;
        end else begin
            post_read_state_s = state_q;
        end
        state_d = post_read_state_s;
        if (latch_cmd_s) begin
            state_d = ST_LATCHED;
        end else if (rw_write_s) begin
            state_d = ST_FREE;
        end else begin
            state_d = post_read_state_s;
        end
    end

    // FSM outputs: read source selection and the byte served for a count read
    always_comb begin
        count_rd_s  = rd_req && !status_sel_s;
        if (state_q == ST_LATCHED) begin
            src_s = latch_q;
        end else begin
            src_s = count_value[15:0];
        end
        case (rw_q)
            2'b01:   count_byte_s = src_s[7:0];
            2'b10:   count_byte_s = src_s[15:8];
            2'b11:   count_byte_s = byte_ptr_q ? src_s[15:8] : src_s[7:0];
            default: count_byte_s = src_s[7:0];
        endcase
        read_done_s = count_rd_s && (state_q == ST_LATCHED)
                      && ((rw_q != 2'b11) || byte_ptr_q);
        latched     = (state_q == ST_LATCHED);
    end

    // Datapath next values: read served first, then the control word and load pulse
    always_comb begin
        rw_d         = rw_q;
        mode_d       = mode_q;
        bcd_d        = bcd_q;
        latch_d      = latch_q;
        byte_ptr_d   = byte_ptr_q;
        null_count_d = null_count_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_req;

        if (count_rd_s) begin
            rd_data_d = count_byte_s;
            if (rw_q == 2'b11) begin
                byte_ptr_d = ~byte_ptr_q;
            end else begin
                byte_ptr_d = byte_ptr_q;
            end
        end else if (rd_req) begin
`ifdef READBACK_STATUS_EN
            rd_data_d = status_q;
`else
            rd_data_d = rd_data_q;
`endif
        end else begin
            rd_data_d = rd_data_q;
        end

        // First latch wins: a latch command only captures when nothing is held after this read
        if (latch_cmd_s && (post_read_state_s == ST_FREE)) begin
            latch_d = count_value[15:0];
        end else begin
            latch_d = latch_q;
        end

        if (rw_write_s) begin
            rw_d         = cw_rw;
            mode_d       = cw_mode;
            bcd_d        = cw_bcd;
            byte_ptr_d   = 1'b0;
            null_count_d = 1'b1;
        end else if (count_loaded) begin
            null_count_d = 1'b0;
        end else begin
            null_count_d = null_count_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rw_q         <= RESET_RW;
            mode_q       <= 3'd0;
            bcd_q        <= 1'b0;
            latch_q      <= 16'h0000;
            byte_ptr_q   <= 1'b0;
            null_count_q <= 1'b1;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
        end else begin
            rw_q         <= rw_d;
            mode_q       <= mode_d;
            bcd_q        <= bcd_d;
            latch_q      <= latch_d;
            byte_ptr_q   <= byte_ptr_d;
            null_count_q <= null_count_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_i8254_count_reader.sv
// Scoreboard bench for i8254_count_reader: directed scenarios plus random traffic against a
// transaction-level model of the channel read side (status tests when READBACK_STATUS_EN is defined).
module tb_i8254_count_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cw_valid;
    logic [1:0]  cw_rw;
    logic [2:0]  cw_mode;
    logic        cw_bcd;
    logic        rd_req;
    logic [15:0] count_value;
    logic        out_pin;
    logic        count_loaded;
    logic        rb_status;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        latched;

    always #5 clk = ~clk;

    i8254_count_reader #(.COUNT_W(16), .RESET_RW(2'b11)) dut (
        .clk(clk), .rst(rst),
        .cw_valid(cw_valid), .cw_rw(cw_rw), .cw_mode(cw_mode), .cw_bcd(cw_bcd),
        .rd_req(rd_req), .count_value(count_value), .out_pin(out_pin),
        .count_loaded(count_loaded),
`ifdef READBACK_STATUS_EN
        .rb_status(rb_status),
`endif
        .rd_data(rd_data), .rd_valid(rd_valid), .latched(latched)
    );

    // Reference model state, in the channel's own terms
    bit [1:0]  m_rw;
    bit [2:0]  m_mode;
    bit        m_bcd;
    bit        m_holding;      // a latched snapshot is still waiting to be read out
    bit [15:0] m_snapshot;
    bit        m_want_msb;     // next byte of a two-byte read is the high byte
    bit        m_null;
    bit        m_status_wait;
    bit [7:0]  m_status;

    bit [7:0]  exp_q[$];
    bit [7:0]  exp_rd_data;
    bit        exp_latched;
    int        errors = 0;
    int        checks = 0;
    bit [15:0] cnt;
    bit        cnt_dec;

    function automatic void model_reset();
        m_rw = 2'b11; m_mode = 3'd0; m_bcd = 1'b0;
        m_holding = 1'b0; m_snapshot = 16'h0000; m_want_msb = 1'b0;
        m_null = 1'b1; m_status_wait = 1'b0; m_status = 8'h00;
        exp_rd_data = 8'h00;
        exp_latched = 1'b0;
    endfunction

    // Apply one cycle of bus activity to the model: read first, then status command, then control word.
    function automatic void model_step(bit r, bit n_rst, bit cv, bit [1:0] crw, bit [2:0] cm, bit cb,
                                       bit [15:0] live, bit op, bit ld, bit rb);
        bit [15:0] word;
        bit [7:0]  b;
        bit        pend_before;
        bit        null_before;
        if (!n_rst) begin
            model_reset();
            return;
        end
        pend_before = m_status_wait;
        null_before = m_null;
        if (r) begin
            if (m_status_wait) begin
                b = m_status;
                m_status_wait = 1'b0;
            end else begin
                word = m_holding ? m_snapshot : live;
                if (m_rw == 2'b01) begin
                    b = word[7:0];
                    m_holding = 1'b0;
                end else if (m_rw == 2'b10) begin
                    b = word[15:8];
                    m_holding = 1'b0;
                end else begin
                    b = m_want_msb ? word[15:8] : word[7:0];
                    if (m_want_msb) m_holding = 1'b0;
                    m_want_msb = !m_want_msb;
                end
            end
            exp_q.push_back(b);
            exp_rd_data = b;
        end
        if (rb && !pend_before) begin
            m_status = {op, null_before, m_rw, m_mode, m_bcd};
            m_status_wait = 1'b1;
        end
        if (cv && crw == 2'b00) begin
            if (!m_holding) begin
                m_holding = 1'b1;
                m_snapshot = live;
            end
        end else if (cv) begin
            m_rw = crw; m_mode = cm; m_bcd = cb;
            m_want_msb = 1'b0; m_holding = 1'b0; m_null = 1'b1;
        end else if (ld) begin
            m_null = 1'b0;
        end
        exp_latched = m_holding;
    endfunction

    // One bus cycle: drive on the falling edge, update the model with the same inputs
    task automatic cyc(input bit r, input bit cv = 1'b0, input bit [1:0] crw = 2'b00,
                       input bit [2:0] cm = 3'd0, input bit cb = 1'b0, input bit rb = 1'b0,
                       input bit n_rst = 1'b1, input bit ld = 1'b0, input bit op = 1'b0);
        @(negedge clk);
        rst = n_rst; rd_req = r; cw_valid = cv; cw_rw = crw; cw_mode = cm; cw_bcd = cb;
        count_value = cnt; out_pin = op; count_loaded = ld;
`ifdef READBACK_STATUS_EN
        rb_status = rb;
`else
        rb_status = 1'b0;
`endif
        model_step(r, n_rst, cv, crw, cm, cb, cnt, op, ld, rb_status);
        if (cnt_dec) cnt = cnt - 16'd1;
    endtask

    // Monitor: compares DUT outputs just after each rising edge against the scoreboard
    always @(posedge clk) begin
        bit [7:0] want;
        #1;
        checks++;
        if (rd_data !== exp_rd_data) begin
            errors++;
            $display("FAIL rd_data_hold: got %h expected %h at %0t", rd_data, exp_rd_data, $time);
        end
        checks++;
        if (latched !== exp_latched) begin
            errors++;
            $display("FAIL latched: got %b expected %b at %0t", latched, exp_latched, $time);
        end
        checks++;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                want = exp_q.pop_front();
                if (rd_data !== want) begin
                    errors++;
                    $display("FAIL rd_byte: got %h expected %h at %0t", rd_data, want, $time);
                end
            end
        end else if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            errors++;
            $display("FAIL rd_valid_missing: got %b expected 1 (byte %h) at %0t", rd_valid, want, $time);
        end else if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_x: got %b expected 0 at %0t", rd_valid, $time);
        end
    end

    initial begin
        model_reset();
        rst = 1'b0; rd_req = 1'b0; cw_valid = 1'b0; cw_rw = 2'b00; cw_mode = 3'd0; cw_bcd = 1'b0;
        count_value = 16'h0000; out_pin = 1'b0; count_loaded = 1'b0; rb_status = 1'b0;
        cnt = 16'h0000; cnt_dec = 1'b0;

        // 1: reset then LSB/MSB read of a steady count
        cnt = 16'hA55A;
        cyc(1'b0, .n_rst(1'b0));
        cyc(1'b0, .n_rst(1'b0));
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);

        // 2: latch while the counter keeps running
        cnt = 16'h1234; cnt_dec = 1'b1;
        cyc(1'b0, .cv(1'b1), .crw(2'b00));
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);

        // 3: second latch before the reads is ignored
        cnt = 16'h1234; cnt_dec = 1'b0;
        cyc(1'b0, .cv(1'b1), .crw(2'b00));
        cnt = 16'h1200;
        cyc(1'b0, .cv(1'b1), .crw(2'b00));
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);

        // 4: rw write between LSB and MSB resets the pointer
        cnt = 16'hBEEF;
        cyc(1'b1);
        cnt = 16'hC0DE;
        cyc(1'b0, .cv(1'b1), .crw(2'b01), .cm(3'd2));
        cyc(1'b1);
        cyc(1'b0, .cv(1'b1), .crw(2'b10), .cm(3'd2));
        cyc(1'b1);
        cyc(1'b0, .cv(1'b1), .crw(2'b11));

        // 5: reset between LSB and MSB of a latched read
        cnt = 16'h5678;
        cyc(1'b0, .cv(1'b1), .crw(2'b00));
        cyc(1'b1);
        cyc(1'b0, .n_rst(1'b0));
        cnt = 16'h9ABC;
        cyc(1'b1);
        cyc(1'b1);

        // read and control word in the same cycle, back-to-back reads
        cnt = 16'h4321;
        cyc(1'b1, .cv(1'b1), .crw(2'b00));
        cyc(1'b1);
        cyc(1'b1, .cv(1'b1), .crw(2'b11), .cm(3'd1));
        cyc(1'b1);
        cyc(1'b0);

`ifdef READBACK_STATUS_EN
        // 6: status read-back then normal count reads
        cnt = 16'h2468;
        cyc(1'b0, .cv(1'b1), .crw(2'b11), .cm(3'd3), .cb(1'b0));
        cyc(1'b0, .rb(1'b1), .op(1'b1));
        cyc(1'b0, .rb(1'b1), .op(1'b0));
        cyc(1'b1, .op(1'b1));
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0, .ld(1'b1));
        cyc(1'b0, .rb(1'b1), .op(1'b1));
        cyc(1'b1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit        r, cv, rb, ld, op, nr;
            bit [1:0]  crw;
            bit [2:0]  cm;
            bit        cb;
            r   = ($urandom_range(0, 99) < 45);
            cv  = ($urandom_range(0, 99) < 12);
            crw = 2'($urandom_range(0, 3));
            cm  = 3'($urandom_range(0, 7));
            cb  = 1'($urandom_range(0, 1));
            rb  = ($urandom_range(0, 99) < 8);
            ld  = ($urandom_range(0, 99) < 10);
            op  = 1'($urandom_range(0, 1));
            nr  = ($urandom_range(0, 99) >= 2);
            cnt_dec = ($urandom_range(0, 3) != 0);
            if (!cnt_dec) cnt = 16'($urandom);
            cyc(r, cv, crw, cm, cb, rb, nr, ld, op);
        end
        cnt_dec = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
